// File: rtl/rave_mmu_pkg.sv
// rave_mmu_pkg: Sv32 PTE layout, walker states and fault codes shared by the MMU walkers
package rave_mmu_pkg;
   localparam int PAGE_SHIFT = 12;
   localparam int VPN_W = 20;
   localparam int PTE_V = 0;
   localparam int PTE_R = 1;
   localparam int PTE_W = 2;
   localparam int PTE_X = 3;
   localparam int PTE_U = 4;
   localparam int PTE_G = 5;
   localparam int PTE_A = 6;
   localparam int PTE_D = 7;
   localparam int PTE_PPN1_HI = 31;
   localparam int PTE_PPN1_LO = 20;
   localparam int PTE_PPN0_HI = 19;
   localparam int PTE_PPN0_LO = 10;
   localparam logic [1:0] CAUSE_PAGE = 2'd0;
   localparam logic [1:0] CAUSE_ACCESS = 2'd1;
   localparam logic [7:0] BARE_PERM = 8'hCF;
   typedef enum logic [2:0] {
      S_IDLE, S_L1_REQ, S_L1_WAIT, S_L0_REQ, S_L0_WAIT, S_FILL, S_FAULT, S_DRAIN
   } ptw_state_t;
endpackage

// File: rtl/f1_pte_check.sv
// f1_pte_check: classifies an Sv32 PTE as leaf/pointer and flags instruction page faults
module f1_pte_check
   import rave_mmu_pkg::*;
(
   input  logic [31:0] pte,
   input  logic        level,
   output logic        is_leaf,
   output logic        page_fault
);
   logic bad_leaf;
   logic unused_bits;
   assign unused_bits = ^{pte[PTE_PPN1_HI:PTE_PPN1_LO], pte[9:8], pte[PTE_D], pte[PTE_G], pte[PTE_U]};
   always_comb begin
      is_leaf = pte[PTE_R] | pte[PTE_X];
      bad_leaf = ~pte[PTE_X] | ~pte[PTE_A] | (level & (pte[PTE_PPN0_HI:PTE_PPN0_LO] != '0));
      page_fault = ~pte[PTE_V] | (~pte[PTE_R] & pte[PTE_W]) | (is_leaf ? bad_leaf : ~level);
   end
endmodule

// File: rtl/f1_ptw_ctrl.sv
// f1_ptw_ctrl: Sv32 fetch page-table walker arbitrating even/odd TLB misses into one fill or fault
module f1_ptw_ctrl
   import rave_mmu_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int CLC_WIDTH = 28
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             miss_even_valid,
   input  logic [19:0]      miss_even_vpn,
   output logic             miss_even_ready,
   input  logic             miss_odd_valid,
   input  logic [19:0]      miss_odd_vpn,
   output logic             miss_odd_ready,
   input  logic             satp_mode,
   input  logic [21:0]      satp_ppn,
   input  logic             flush,
   output logic             mem_req_valid,
   input  logic             mem_req_ready,
   output logic [XLEN-1:0]  mem_req_addr,
   input  logic             mem_rsp_valid,
   input  logic [31:0]      mem_rsp_data,
   input  logic             mem_rsp_err,
   output logic             fill_valid,
   output logic [19:0]      fill_vpn,
   output logic [XLEN-13:0] fill_ppn,
   output logic [7:0]       fill_perm,
   output logic             fill_super,
   output logic             fault_valid,
   output logic [1:0]       fault_cause,
   output logic [19:0]      fault_vpn
);
   ptw_state_t state, nxt;
   logic [VPN_W-1:0] vpn_q;
   logic [21:0] tbl_q, tbl;
   logic [9:0] idx;
   logic [33:0] addr_full;
   logic lvl1, hs, accept, bare, is_leaf, page_fault;
   logic unused_clc;
   assign unused_clc = CLC_WIDTH > VPN_W;
   f1_pte_check u_chk (.pte(mem_rsp_data), .level(lvl1), .is_leaf, .page_fault);
   assign lvl1 = (state == S_L1_REQ) || (state == S_L1_WAIT);
   assign bare = state == S_L1_REQ;
   assign miss_even_ready = (state == S_IDLE) && !flush && !rst;
   assign miss_odd_ready = miss_even_ready && (!miss_even_valid || miss_even_vpn == miss_odd_vpn);
   assign accept = miss_even_ready && (miss_even_valid || miss_odd_valid);
   assign mem_req_valid = (state == S_L1_REQ && satp_mode) || state == S_L0_REQ;
   assign hs = mem_req_valid && mem_req_ready;
   assign tbl = lvl1 ? satp_ppn : tbl_q;
   assign idx = lvl1 ? vpn_q[19:10] : vpn_q[9:0];
   assign addr_full = {tbl, 12'h000} + {22'h0, idx, 2'b00};
   assign mem_req_addr = mem_req_valid ? XLEN'(addr_full) : '0;
   assign fill_valid = state == S_FILL && !flush;
   assign fault_valid = state == S_FAULT && !flush;
   // Once a request has been accepted its response must be swallowed, so flush goes via DRAIN.
   always_comb begin
      nxt = state;
      case (state)
         S_IDLE:    nxt = accept ? S_L1_REQ : S_IDLE;
         S_L1_REQ,
         S_L0_REQ:  nxt = hs ? (flush ? S_DRAIN : (lvl1 ? S_L1_WAIT : S_L0_WAIT))
                        : flush ? S_IDLE : (lvl1 && !satp_mode) ? S_FILL : state;
         S_L1_WAIT,
         S_L0_WAIT: nxt = !mem_rsp_valid ? (flush ? S_DRAIN : state)
                        : flush ? S_IDLE : (mem_rsp_err || page_fault) ? S_FAULT
                        : is_leaf ? S_FILL : S_L0_REQ;
         S_DRAIN:   nxt = mem_rsp_valid ? S_IDLE : S_DRAIN;
         default:   nxt = S_IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
         vpn_q <= '0;
         tbl_q <= '0;
         fill_vpn <= '0;
         fill_ppn <= '0;
         fill_perm <= '0;
         fill_super <= 1'b0;
         fault_cause <= '0;
         fault_vpn <= '0;
      end else begin
         state <= nxt;
         if (accept) vpn_q <= miss_even_valid ? miss_even_vpn : miss_odd_vpn;
         if (state == S_L1_WAIT && mem_rsp_valid) tbl_q <= mem_rsp_data[PTE_PPN1_HI:PTE_PPN0_LO];
         if (nxt == S_FILL) begin
            fill_vpn <= vpn_q;
            fill_ppn <= bare ? (XLEN-12)'(vpn_q) : (XLEN-12)'(mem_rsp_data[PTE_PPN1_HI:PTE_PPN0_LO]);
            fill_perm <= bare ? BARE_PERM : mem_rsp_data[7:0];
            fill_super <= state == S_L1_WAIT;
         end
         if (nxt == S_FAULT) begin
            fault_vpn <= vpn_q;
            fault_cause <= mem_rsp_err ? CAUSE_ACCESS : CAUSE_PAGE;
         end
      end
   end
endmodule

// File: tb/tb_f1_ptw_ctrl.sv
// tb_f1_ptw_ctrl: scoreboard bench for the Sv32 fetch page-table walker
module tb_f1_ptw_ctrl;
   localparam int K_ACC = 0;
   localparam int K_REQ = 1;
   localparam int K_FILL = 2;
   localparam int K_FAULT = 3;
   typedef struct {
      int kind;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] c;
      int d;
   } ev_t;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic miss_even_valid = 1'b0, miss_odd_valid = 1'b0;
   logic [19:0] miss_even_vpn = '0, miss_odd_vpn = '0;
   logic miss_even_ready, miss_odd_ready;
   logic satp_mode = 1'b1;
   logic [21:0] satp_ppn = 22'h80;
   logic flush = 1'b0;
   logic mem_req_valid, mem_req_ready = 1'b1;
   logic [31:0] mem_req_addr;
   logic mem_rsp_valid = 1'b0, mem_rsp_err = 1'b0;
   logic [31:0] mem_rsp_data = '0;
   logic fill_valid, fill_super, fault_valid;
   logic [19:0] fill_vpn, fill_ppn, fault_vpn;
   logic [7:0] fill_perm;
   logic [1:0] fault_cause;
   ev_t q[$];
   int errors = 0, checks = 0, cyc = 0, last_cyc = 0;

   f1_ptw_ctrl #(.XLEN(32), .CLC_WIDTH(28)) dut (
      .clk(clk), .rst(rst),
      .miss_even_valid(miss_even_valid), .miss_even_vpn(miss_even_vpn), .miss_even_ready(miss_even_ready),
      .miss_odd_valid(miss_odd_valid), .miss_odd_vpn(miss_odd_vpn), .miss_odd_ready(miss_odd_ready),
      .satp_mode(satp_mode), .satp_ppn(satp_ppn), .flush(flush),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
      .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .mem_rsp_err(mem_rsp_err),
      .fill_valid(fill_valid), .fill_vpn(fill_vpn), .fill_ppn(fill_ppn), .fill_perm(fill_perm),
      .fill_super(fill_super), .fault_valid(fault_valid), .fault_cause(fault_cause), .fault_vpn(fault_vpn)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic expect_ev(input int kind, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] c, input int d);
      ev_t e;
      e.kind = kind; e.a = a; e.b = b; e.c = c; e.d = d;
      q.push_back(e);
   endtask

   task automatic got(input int kind, input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
      ev_t e;
      checks++;
      if (q.size() == 0) begin
         errors++;
         $display("FAIL unexpected event: got kind=%0d a=%h b=%h c=%h, required none", kind, a, b, c);
      end else begin
         e = q.pop_front();
         if (e.kind != kind || e.a != a || e.b != b || e.c != c || (e.d >= 0 && cyc - last_cyc != e.d)) begin
            errors++;
            $display("FAIL event: got kind=%0d a=%h b=%h c=%h dly=%0d, required kind=%0d a=%h b=%h c=%h dly=%0d",
                     kind, a, b, c, cyc - last_cyc, e.kind, e.a, e.b, e.c, e.d);
         end
      end
      last_cyc = cyc;
   endtask

   always @(negedge clk) if (!rst) begin
      if ((miss_even_valid && miss_even_ready) || (miss_odd_valid && miss_odd_ready))
         got(K_ACC, {30'd0, miss_even_valid && miss_even_ready, miss_odd_valid && miss_odd_ready}, 0, 0);
      if (mem_req_valid && mem_req_ready) got(K_REQ, mem_req_addr, 0, 0);
      if (fill_valid) got(K_FILL, {12'd0, fill_vpn}, {12'd0, fill_ppn}, {23'd0, fill_super, fill_perm});
      if (fault_valid) got(K_FAULT, {12'd0, fault_vpn}, {30'd0, fault_cause}, 0);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic miss(input logic ev, input logic [19:0] evpn, input logic ov, input logic [19:0] ovpn);
      miss_even_valid = ev; miss_even_vpn = evpn; miss_odd_valid = ov; miss_odd_vpn = ovpn;
      tick(1);
      miss_even_valid = 1'b0; miss_odd_valid = 1'b0;
   endtask

   task automatic wait_hs();
      int n = 0;
      while (!(mem_req_valid && mem_req_ready) && n < 50) begin
         tick(1);
         n++;
      end
      if (n >= 50) begin
         checks++;
         errors++;
         $display("FAIL handshake timeout: got no request, required one");
      end
      tick(1);
   endtask

   task automatic serve(input logic [31:0] pte, input logic err, input int gap);
      wait_hs();
      if (gap > 0) tick(gap);
      mem_rsp_valid = 1'b1; mem_rsp_data = pte; mem_rsp_err = err;
      tick(1);
      mem_rsp_valid = 1'b0; mem_rsp_data = '0; mem_rsp_err = 1'b0;
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: got no finish, required finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] bad_pte [4];
      int n;
      bad_pte[0] = 32'h0; bad_pte[1] = 32'h05; bad_pte[2] = 32'h43; bad_pte[3] = 32'h0B;
      tick(2);
      check("rst mem_req_valid", {31'd0, mem_req_valid}, 0);
      check("rst fill_valid", {31'd0, fill_valid}, 0);
      check("rst fault_valid", {31'd0, fault_valid}, 0);
      check("rst even_ready", {31'd0, miss_even_ready}, 0);
      check("rst fill_vpn", {12'd0, fill_vpn}, 0);
      rst = 1'b0;
      #1;
      check("idle even_ready", {31'd0, miss_even_ready}, 1);
      tick(1);
      // Sv32 4 KiB walk
      expect_ev(K_ACC, 2, 0, 0, -1);
      expect_ev(K_REQ, 32'h80120, 0, 0, 1);
      expect_ev(K_REQ, 32'h100D14, 0, 0, 2);
      expect_ev(K_FILL, 32'h12345, 32'h0048D, 32'h04B, 2);
      miss(1, 20'h12345, 0, 0);
      serve(32'h00040001, 0, 0);
      serve(32'h0012344B, 0, 0);
      tick(2);
      // superpage and misaligned superpage
      expect_ev(K_ACC, 2, 0, 0, -1);
      expect_ev(K_REQ, 32'h80120, 0, 0, 1);
      expect_ev(K_FILL, 32'h12345, 32'h80000, 32'h14B, 2);
      miss(1, 20'h12345, 0, 0);
      serve(32'h2000004B, 0, 0);
      tick(2);
      expect_ev(K_ACC, 2, 0, 0, -1);
      expect_ev(K_REQ, 32'h80120, 0, 0, 1);
      expect_ev(K_FAULT, 32'h12345, 0, 0, 2);
      miss(1, 20'h12345, 0, 0);
      serve(32'h2000044B, 0, 0);
      tick(2);
      // L1 page faults
      for (int i = 0; i < 4; i++) begin
         expect_ev(K_ACC, 2, 0, 0, -1);
         expect_ev(K_REQ, 32'h80120, 0, 0, 1);
         expect_ev(K_FAULT, 32'h12345, 0, 0, 2);
         miss(1, 20'h12345, 0, 0);
         serve(bad_pte[i], 0, 0);
         tick(2);
      end
      expect_ev(K_ACC, 2, 0, 0, -1);
      expect_ev(K_REQ, 32'h80120, 0, 0, 1);
      expect_ev(K_REQ, 32'h100D14, 0, 0, 2);
      expect_ev(K_FAULT, 32'h12345, 0, 0, 2);
      miss(1, 20'h12345, 0, 0);
      serve(32'h00040001, 0, 0);
      serve(32'h00000001, 0, 0);
      tick(2);
      expect_ev(K_ACC, 2, 0, 0, -1);
      expect_ev(K_REQ, 32'h80120, 0, 0, 1);
      expect_ev(K_FAULT, 32'h12345, 1, 0, 2);
      miss(1, 20'h12345, 0, 0);
      serve(32'h2000004B, 1, 0);
      tick(2);
      // arbitration: distinct VPNs, even first, odd one cycle after the fill
      expect_ev(K_ACC, 2, 0, 0, -1);
      expect_ev(K_REQ, 32'h80110, 0, 0, 1);
      expect_ev(K_FILL, 32'h11111, 32'h80000, 32'h14B, 2);
      expect_ev(K_ACC, 1, 0, 0, 1);
      expect_ev(K_REQ, 32'h80110, 0, 0, 1);
      expect_ev(K_FILL, 32'h11112, 32'h80000, 32'h14B, 2);
      miss_even_valid = 1; miss_even_vpn = 20'h11111; miss_odd_valid = 1; miss_odd_vpn = 20'h11112;
      tick(1);
      miss_even_valid = 0;
      serve(32'h2000004B, 0, 0);
      n = 0;
      while (!miss_odd_ready && n < 20) begin
         tick(1);
         n++;
      end
      tick(1);
      miss_odd_valid = 0;
      serve(32'h2000004B, 0, 0);
      tick(2);
      // arbitration: equal VPNs share one walk
      expect_ev(K_ACC, 3, 0, 0, -1);
      expect_ev(K_REQ, 32'h80220, 0, 0, 1);
      expect_ev(K_FILL, 32'h22222, 32'h80000, 32'h14B, 2);
      miss(1, 20'h22222, 1, 20'h22222);
      serve(32'h2000004B, 0, 0);
      tick(2);
      // flush in L1_WAIT drains the late response
      expect_ev(K_ACC, 2, 0, 0, -1);
      expect_ev(K_REQ, 32'h80120, 0, 0, 1);
      miss(1, 20'h12345, 0, 0);
      wait_hs();
      flush = 1;
      tick(1);
      flush = 0;
      check("drain even_ready", {31'd0, miss_even_ready}, 0);
      tick(2);
      mem_rsp_valid = 1; mem_rsp_data = 32'h2000004B;
      tick(1);
      mem_rsp_valid = 0; mem_rsp_data = 0;
      check("post drain even_ready", {31'd0, miss_even_ready}, 1);
      expect_ev(K_ACC, 2, 0, 0, -1);
      expect_ev(K_REQ, 32'h80120, 0, 0, 1);
      expect_ev(K_FILL, 32'h12345, 32'h80000, 32'h14B, 2);
      miss(1, 20'h12345, 0, 0);
      serve(32'h2000004B, 0, 0);
      tick(2);
      // flush in L0_REQ without handshake
      expect_ev(K_ACC, 2, 0, 0, -1);
      expect_ev(K_REQ, 32'h80120, 0, 0, 1);
      miss(1, 20'h12345, 0, 0);
      serve(32'h00040001, 0, 0);
      mem_req_ready = 0;
      check("L0 req valid", {31'd0, mem_req_valid}, 1);
      check("L0 req addr", mem_req_addr, 32'h100D14);
      flush = 1;
      tick(1);
      flush = 0;
      check("req drop after flush", {31'd0, mem_req_valid}, 0);
      mem_req_ready = 1;
      tick(2);
      // backpressure keeps the request stable
      expect_ev(K_ACC, 2, 0, 0, -1);
      expect_ev(K_REQ, 32'h80120, 0, 0, -1);
      expect_ev(K_FILL, 32'h12345, 32'h80000, 32'h14B, 2);
      mem_req_ready = 0;
      miss(1, 20'h12345, 0, 0);
      for (int i = 0; i < 5; i++) begin
         check("stall req valid", {31'd0, mem_req_valid}, 1);
         check("stall req addr", mem_req_addr, 32'h80120);
         tick(1);
      end
      mem_req_ready = 1;
      serve(32'h2000004B, 0, 0);
      tick(2);
      // reset mid-walk
      expect_ev(K_ACC, 2, 0, 0, -1);
      expect_ev(K_REQ, 32'h80120, 0, 0, 1);
      miss(1, 20'h12345, 0, 0);
      wait_hs();
      rst = 1;
      tick(1);
      check("mid rst req_valid", {31'd0, mem_req_valid}, 0);
      check("mid rst req_addr", mem_req_addr, 0);
      check("mid rst fill_vpn", {12'd0, fill_vpn}, 0);
      check("mid rst fill_ppn", {12'd0, fill_ppn}, 0);
      check("mid rst fill_perm/super", {23'd0, fill_super, fill_perm}, 0);
      check("mid rst fault_vpn", {12'd0, fault_vpn}, 0);
      check("mid rst fault_cause", {30'd0, fault_cause}, 0);
      check("mid rst strobes/readies", {28'd0, fill_valid, fault_valid, miss_even_ready, miss_odd_ready}, 0);
      rst = 0;
      tick(1);
      // bare mode: identity fill two cycles after accept, no memory traffic
      satp_mode = 0;
      expect_ev(K_ACC, 2, 0, 0, -1);
      expect_ev(K_FILL, 32'h0ABCD, 32'h0ABCD, 32'h0CF, 2);
      miss(1, 20'h0ABCD, 0, 0);
      tick(4);
      check("scoreboard drained", q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
